iram_resp: RTL

//   Instruction-RAM responder: the memory end of the fetch unit's IRAM

---
 rtl/iram_resp.sv | 108 ++++++++++
 1 files changed

// File: rtl/iram_resp.sv
// Instruction-RAM responder: loads a little-endian byte image after reset,
// then answers fetch reads with one cycle of latency. The fetch core is held until the load completes.
module iram_resp #(
  parameter int IRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRAM_AW-1:0] i_iram_addr,
  input  logic               i_iram_re,
  output logic [31:0]        o_iram_rdata,
  output logic               o_iram_rvalid,
  input  logic               i_ld_valid,
  input  logic [7:0]         i_ld_data,
  input  logic               i_ld_last,
  output logic               o_ld_ready,
  output logic               o_core_hold,
  output logic               o_ld_err
);

  localparam int DEPTH = 1 << IRAM_AW;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERR} state_t;

  state_t             state_q;
  logic [1:0]         lane_q;
  logic [IRAM_AW:0]   wcnt_q;
  logic [31:0]        asm_q;
  logic [31:0]        rdata_q;
  logic               rvalid_q;
  logic               ld_ready_q;
  logic               core_hold_q;
  logic               ld_err_q;
  logic [31:0]        mem [DEPTH];

  logic               ld_acc;
  logic               ovf;
  logic               wr_en;
  logic [31:0]        word_d;

  // The assembly register holds only already-filled lower lanes, so any unfilled upper lane is zero.
  always_comb begin
    ld_acc = i_ld_valid & ld_ready_q & (state_q == S_LOAD);
    ovf    = (wcnt_q == (IRAM_AW+1)'(DEPTH));
    word_d = asm_q | ({24'd0, i_ld_data} << {lane_q, 3'b000});
    wr_en  = ld_acc & ~ovf & ((lane_q == 2'd3) | i_ld_last);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wcnt_q[IRAM_AW-1:0]] <= word_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      lane_q      <= 2'd0;
      wcnt_q      <= '0;
      asm_q       <= 32'd0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      ld_ready_q  <= 1'b1;
      core_hold_q <= 1'b1;
      ld_err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (ld_acc) begin
            if (ovf) begin
              state_q    <= S_ERR;
              ld_ready_q <= 1'b0;
              ld_err_q   <= 1'b1;
            end else begin
              lane_q <= lane_q + 2'd1;
              if (wr_en) begin
                asm_q  <= 32'd0;
                wcnt_q <= wcnt_q + (IRAM_AW+1)'(1);
              end else begin
                asm_q  <= word_d;
              end
              if (i_ld_last) begin
                state_q     <= S_RUN;
                ld_ready_q  <= 1'b0;
                core_hold_q <= 1'b0;
              end
            end
          end
        end
        S_RUN: begin
          rvalid_q <= i_iram_re;
          if (i_iram_re) begin
            rdata_q <= mem[i_iram_addr];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_iram_rdata  = rdata_q;
  assign o_iram_rvalid = rvalid_q;
  assign o_ld_ready    = ld_ready_q;
  assign o_core_hold   = core_hold_q;
  assign o_ld_err      = ld_err_q;

endmodule
